// File: rtl/mul_share_if.sv
// Bundle between the shared-multiplier arbiter, its requesters and the multiplier.
// slave is the arbiter's view and master is the environment's view.
interface mul_share_if #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]                req_valid;
    logic [NREQ-1:0]                req_ready;
    logic [NREQ-1:0][WIDTH-1:0]     req_a;
    logic [NREQ-1:0][WIDTH-1:0]     req_b;
    logic [NREQ-1:0]                rsp_valid;
    logic [NREQ-1:0]                rsp_ready;
    logic [NREQ-1:0][2*WIDTH-1:0]   rsp_y;
    logic [WIDTH-1:0]               mul_a;
    logic [WIDTH-1:0]               mul_b;
    logic [2*WIDTH-1:0]             mul_y;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_y,
        output req_ready, rsp_valid, rsp_y, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_y,
        input  req_ready, rsp_valid, rsp_y, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters.
// A tag shadow pipeline routes each product to its requester's response register.
module mul_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int LAT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    mul_share_if.slave bus,
    output logic       idle
);
    localparam int PW = $clog2(NREQ);
    typedef logic [PW-1:0] idx_t;

    idx_t                          ptr_q, ptr_d;
    logic [NREQ-1:0]               pend_q, pend_d;
    logic [NREQ-1:0]               rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0][2*WIDTH-1:0]  rsp_y_q, rsp_y_d;
    logic [LAT-1:0]                v_q, v_d;
    logic [LAT-1:0][PW-1:0]        tag_q, tag_d;

    logic [NREQ-1:0] elig;
    logic            gnt_vld;
    idx_t            gnt_idx;
    logic [PW:0]     scan;

    assign elig = bus.req_valid & ~pend_q;

    // Scan from ptr upward with wrap; first eligible requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
            if (!gnt_vld && elig[scan[PW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        if (gnt_vld) begin
            bus.req_ready[gnt_idx] = 1'b1;
            bus.mul_a              = bus.req_a[gnt_idx];
            bus.mul_b              = bus.req_b[gnt_idx];
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        pend_d      = pend_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        v_d[0]      = gnt_vld;
        tag_d[0]    = gnt_idx;
        for (int s = 1; s < LAT; s++) begin
            v_d[s]   = v_q[s-1];
            tag_d[s] = tag_q[s-1];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
                pend_d[i]      = 1'b0;
            end
        end
        // The capture slot is always free: pend blocks re-issue until the handshake.
        if (v_q[LAT-1]) begin
            rsp_valid_d[tag_q[LAT-1]] = 1'b1;
            rsp_y_d[tag_q[LAT-1]]     = bus.mul_y;
        end
        if (gnt_vld) begin
            pend_d[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == idx_t'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            pend_q      <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            v_q         <= '0;
            tag_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            v_q         <= v_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign idle          = (pend_q == '0);
endmodule
